// File: rtl/gluclock_rtc_pkg.sv
// Shared constants and calendar helpers for the gluclock MC146818-style RTC.
// Field values are held in BCD or binary depending on regB.DM.
package gluclock_rtc_pkg;

    localparam logic [7:0] RTC_SEC      = 8'h00;
    localparam logic [7:0] RTC_SEC_ALM  = 8'h01;
    localparam logic [7:0] RTC_MIN      = 8'h02;
    localparam logic [7:0] RTC_MIN_ALM  = 8'h03;
    localparam logic [7:0] RTC_HR       = 8'h04;
    localparam logic [7:0] RTC_HR_ALM   = 8'h05;
    localparam logic [7:0] RTC_DOW      = 8'h06;
    localparam logic [7:0] RTC_DATE     = 8'h07;
    localparam logic [7:0] RTC_MONTH    = 8'h08;
    localparam logic [7:0] RTC_YEAR     = 8'h09;
    localparam logic [7:0] RTC_REGA     = 8'h0A;
    localparam logic [7:0] RTC_REGB     = 8'h0B;
    localparam logic [7:0] RTC_REGC     = 8'h0C;
    localparam logic [7:0] RTC_REGD     = 8'h0D;
    localparam logic [7:0] RTC_RAM_BASE = 8'h0E;

    localparam int SET_BIT  = 7;
    localparam int DM_BIT   = 2;
    localparam int H24_BIT  = 1;
    localparam int UIP_BIT  = 7;
    localparam int AF_BIT   = 5;
    localparam int UF_BIT   = 4;
    localparam int IRQF_BIT = 7;

    typedef enum int {F_SEC, F_MIN, F_HR, F_DOW, F_DATE, F_MON, F_YEAR} field_e;
    localparam int NUM_FIELDS = 7;

    function automatic logic [7:0] bcd2bin(input logic [7:0] v);
        return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // Converts a binary constant into the encoding currently selected by DM.
    function automatic logic [7:0] encode(input logic [7:0] v, input logic dm);
        return dm ? v : bin2bcd(v);
    endfunction

    function automatic logic [7:0] month_len(input logic [7:0] month,
                                             input logic [7:0] year,
                                             input logic       dm);
        logic [7:0] m;
        logic [7:0] y;
        logic [7:0] d;
        m = dm ? month : bcd2bin(month);
        y = dm ? year  : bcd2bin(year);
        case (m)
            8'd2:                      d = (y[1:0] == 2'b00) ? 8'd29 : 8'd28;
            8'd4, 8'd6, 8'd9, 8'd11:   d = 8'd30;
            default:                   d = 8'd31;
        endcase
        return encode(d, dm);
    endfunction

    // Alarm bytes with bits 7:6 = 11 are "don't care" and match any value.
    function automatic logic alarm_hit(input logic [7:0] alm, input logic [7:0] val);
        return (alm[7:6] == 2'b11) || (alm == val);
    endfunction

endpackage

// File: rtl/gluclock_rtc_if.sv
// CMOS port access bus between the gluclock wait logic (master) and the RTC (slave).
interface gluclock_rtc_if;
    logic       req;
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] wrdata;
    logic [7:0] rddata;
    logic       rd_valid;

    modport master (output req, rnw, addr, wrdata, input rddata, rd_valid);
    modport slave  (input req, rnw, addr, wrdata, output rddata, rd_valid);
endinterface

// File: rtl/gluclock_rtc_field_cnt.sv
// One calendar field: BCD/binary increment with wrap-to-min and carry out.
// A CPU write in the same cycle overrides the increment and suppresses the carry.
module rtc_field_cnt #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       fclk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       dm,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       wr_en,
    input  logic [7:0] wr_val,
    output logic [7:0] value,
    output logic [7:0] value_nxt,
    output logic       carry
);

    logic       at_max;
    logic [7:0] incr;

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        at_max    = (value >= max);
        if (dm || value[3:0] < 4'd9) incr = value + 8'd1;
        else                          incr = {value[7:4] + 4'd1, 4'd0};
        value_nxt = value;
        if (wr_en)    value_nxt = wr_val;
        else if (inc) value_nxt = at_max ? min : incr;
        carry     = inc & at_max & ~wr_en;
    end

    // NOTE: sequential state uses non-blocking assignment so all fields see pre-edge values.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) value <= RST_VAL;
        else        value <= value_nxt;
    end

endmodule

// File: rtl/gluclock_rtc.sv
// MC146818-style CMOS/RTC serving the gluclock wait handshake: calendar clock,
// status registers A-D, alarms and general-purpose CMOS RAM.
module gluclock_rtc
    import gluclock_rtc_pkg::*;
#(
    parameter int TICK_DIV = 28000000,
    parameter int UIP_LEAD = 64
) (
    input  logic              fclk,
    input  logic              rst_n,
    gluclock_rtc_if.slave     bus,
    output logic              sec_tick
);

    localparam int PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RAM_DEPTH = 256 - int'(RTC_RAM_BASE);

    logic [PW-1:0] presc;
    logic [6:0]    rega_lo;
    logic [7:0]    regb;
    logic [7:0]    sec_alm, min_alm, hr_alm;
    logic          af, uf;
    logic [7:0]    ram [RAM_DEPTH];

    logic [7:0]    f_val   [NUM_FIELDS];
    logic [7:0]    f_nxt   [NUM_FIELDS];
    logic          f_carry [NUM_FIELDS];

    logic       wr, rd, set_mode, dm, update, uip, af_set;
    logic [7:0] ram_idx, rd_mux;

    assign wr       = bus.req & ~bus.rnw;
    assign rd       = bus.req &  bus.rnw;
    assign set_mode = regb[SET_BIT];
    assign dm       = regb[DM_BIT];
    assign update   = ~set_mode & (presc == PW'(TICK_DIV - 1));
    assign uip      = (presc >= PW'(TICK_DIV - UIP_LEAD));
    assign ram_idx  = bus.addr - RTC_RAM_BASE;

    // The alarm compares against the post-update time, so a CPU write that
    // lands in the update cycle is what the alarm sees.
    assign af_set = update & alarm_hit(sec_alm, f_nxt[F_SEC])
                           & alarm_hit(min_alm, f_nxt[F_MIN])
                           & alarm_hit(hr_alm,  f_nxt[F_HR]);

    rtc_field_cnt #(.RST_VAL(8'h00)) u_sec (
        .fclk, .rst_n, .inc(update), .dm, .min(8'h00), .max(encode(8'd59, dm)),
        .wr_en(wr && bus.addr == RTC_SEC), .wr_val(bus.wrdata),
        .value(f_val[F_SEC]), .value_nxt(f_nxt[F_SEC]), .carry(f_carry[F_SEC]));

    rtc_field_cnt #(.RST_VAL(8'h00)) u_min (
        .fclk, .rst_n, .inc(f_carry[F_SEC]), .dm, .min(8'h00), .max(encode(8'd59, dm)),
        .wr_en(wr && bus.addr == RTC_MIN), .wr_val(bus.wrdata),
        .value(f_val[F_MIN]), .value_nxt(f_nxt[F_MIN]), .carry(f_carry[F_MIN]));

    rtc_field_cnt #(.RST_VAL(8'h00)) u_hr (
        .fclk, .rst_n, .inc(f_carry[F_MIN]), .dm, .min(8'h00), .max(encode(8'd23, dm)),
        .wr_en(wr && bus.addr == RTC_HR), .wr_val(bus.wrdata),
        .value(f_val[F_HR]), .value_nxt(f_nxt[F_HR]), .carry(f_carry[F_HR]));

    rtc_field_cnt #(.RST_VAL(8'h01)) u_dow (
        .fclk, .rst_n, .inc(f_carry[F_HR]), .dm, .min(8'h01), .max(8'h07),
        .wr_en(wr && bus.addr == RTC_DOW), .wr_val(bus.wrdata),
        .value(f_val[F_DOW]), .value_nxt(f_nxt[F_DOW]), .carry(f_carry[F_DOW]));

    rtc_field_cnt #(.RST_VAL(8'h01)) u_date (
        .fclk, .rst_n, .inc(f_carry[F_HR]), .dm, .min(8'h01),
        .max(month_len(f_val[F_MON], f_val[F_YEAR], dm)),
        .wr_en(wr && bus.addr == RTC_DATE), .wr_val(bus.wrdata),
        .value(f_val[F_DATE]), .value_nxt(f_nxt[F_DATE]), .carry(f_carry[F_DATE]));

    rtc_field_cnt #(.RST_VAL(8'h01)) u_mon (
        .fclk, .rst_n, .inc(f_carry[F_DATE]), .dm, .min(8'h01), .max(encode(8'd12, dm)),
        .wr_en(wr && bus.addr == RTC_MONTH), .wr_val(bus.wrdata),
        .value(f_val[F_MON]), .value_nxt(f_nxt[F_MON]), .carry(f_carry[F_MON]));

    rtc_field_cnt #(.RST_VAL(8'h00)) u_year (
        .fclk, .rst_n, .inc(f_carry[F_MON]), .dm, .min(8'h00), .max(encode(8'd99, dm)),
        .wr_en(wr && bus.addr == RTC_YEAR), .wr_val(bus.wrdata),
        .value(f_val[F_YEAR]), .value_nxt(f_nxt[F_YEAR]), .carry(f_carry[F_YEAR]));

    always_comb begin
        rd_mux = 8'h00;
        case (bus.addr)
            RTC_SEC:     rd_mux = f_val[F_SEC];
            RTC_SEC_ALM: rd_mux = sec_alm;
            RTC_MIN:     rd_mux = f_val[F_MIN];
            RTC_MIN_ALM: rd_mux = min_alm;
            RTC_HR:      rd_mux = f_val[F_HR];
            RTC_HR_ALM:  rd_mux = hr_alm;
            RTC_DOW:     rd_mux = f_val[F_DOW];
            RTC_DATE:    rd_mux = f_val[F_DATE];
            RTC_MONTH:   rd_mux = f_val[F_MON];
            RTC_YEAR:    rd_mux = f_val[F_YEAR];
            RTC_REGA:    rd_mux = {uip, rega_lo};
            RTC_REGB:    rd_mux = regb;
            RTC_REGC: begin
                rd_mux[IRQF_BIT] = af | uf;
                rd_mux[AF_BIT]   = af;
                rd_mux[UF_BIT]   = uf;
            end
            RTC_REGD:    rd_mux = 8'h80;
            default:     rd_mux = ram[ram_idx];
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            rega_lo      <= 7'h20;
            regb         <= 8'h02;
            sec_alm      <= 8'h00;
            min_alm      <= 8'h00;
            hr_alm       <= 8'h00;
            af           <= 1'b0;
            uf           <= 1'b0;
            sec_tick     <= 1'b0;
            bus.rddata   <= 8'h00;
            bus.rd_valid <= 1'b0;
        end else begin
            sec_tick     <= update;
            bus.rd_valid <= rd;
            if (rd) bus.rddata <= rd_mux;

            if (set_mode || update) presc <= '0;
            else                    presc <= presc + PW'(1);

            if (wr) begin
                case (bus.addr)
                    RTC_SEC_ALM: sec_alm <= bus.wrdata;
                    RTC_MIN_ALM: min_alm <= bus.wrdata;
                    RTC_HR_ALM:  hr_alm  <= bus.wrdata;
                    RTC_REGA:    rega_lo <= bus.wrdata[6:0];
                    RTC_REGB:    regb    <= bus.wrdata;
                    default: ;
                endcase
            end

            // A flag raised by this cycle's update must survive a regC read-clear,
            // so the set is placed after the clear and wins.
            if (rd && bus.addr == RTC_REGC) begin
                af <= 1'b0;
                uf <= 1'b0;
            end
            if (update) begin
                uf <= 1'b1;
                if (af_set) af <= 1'b1;
            end
        end
    end

    // NOTE: the CMOS RAM has no reset so it maps onto block RAM; its contents start undefined.
    always_ff @(posedge fclk) begin
        if (wr && bus.addr >= RTC_RAM_BASE) ram[ram_idx] <= bus.wrdata;
    end

endmodule

// File: tb/tb_gluclock_rtc.sv
// Directed bench for gluclock_rtc with a short prescaler period so ticks fit in a few hundred cycles.
module tb_gluclock_rtc;
    import gluclock_rtc_pkg::*;

    localparam int TICK_DIV = 100;
    localparam int UIP_LEAD = 8;

    logic fclk = 1'b0;
    logic rst_n = 1'b0;
    logic sec_tick;
    int   checks = 0;
    int   errors = 0;

    gluclock_rtc_if bus ();

    gluclock_rtc #(.TICK_DIV(TICK_DIV), .UIP_LEAD(UIP_LEAD)) dut (
        .fclk     (fclk),
        .rst_n    (rst_n),
        .bus      (bus),
        .sec_tick (sec_tick)
    );

    always #5 fclk = ~fclk;

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = 1'b0; bus.rnw = 1'b1; bus.addr = 8'h00; bus.wrdata = 8'h00;
        rst_n = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.req = 1'b1; bus.rnw = 1'b0; bus.addr = a; bus.wrdata = d;
        step();
        bus.req = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d, output logic v);
        bus.req = 1'b1; bus.rnw = 1'b1; bus.addr = a;
        step();
        bus.req = 1'b0;
        d = bus.rddata;
        v = bus.rd_valid;
    endtask

    // Returns the number of edges until sec_tick is seen, or -1 if the budget expires.
    task automatic wait_tick(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (sec_tick) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] exp_d [4];
        logic [7:0] adr [4];
        logic [7:0] d;
        logic v;
        adr   = '{RTC_REGD, RTC_REGB, RTC_REGA, RTC_DATE};
        exp_d = '{8'h80, 8'h02, 8'h20, 8'h01};
        do_reset();
        checks++;
        if (bus.rd_valid !== 1'b0 || sec_tick !== 1'b0 || bus.rddata !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: rd_valid=%b sec_tick=%b rddata=%h, want 0 0 00",
                     bus.rd_valid, sec_tick, bus.rddata);
        end
        for (int i = 0; i < 4; i++) begin
            rd(adr[i], d, v);
            checks++;
            if (d !== exp_d[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL reset_read_%h: data=%h valid=%b, want %h 1", adr[i], d, v, exp_d[i]);
            end
        end
        step();
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_one_cycle: got %b want 0", bus.rd_valid);
        end
    endtask

    task automatic test_rollover(input logic [7:0] year, input logic [7:0] exp_date,
                                 input logic [7:0] exp_mon);
        logic [7:0] adr [6];
        logic [7:0] exp_d [6];
        logic [7:0] d;
        logic v;
        int n;
        adr   = '{RTC_SEC, RTC_MIN, RTC_HR, RTC_DATE, RTC_MONTH, RTC_YEAR};
        exp_d = '{8'h00, 8'h00, 8'h00, exp_date, exp_mon, year};
        do_reset();
        wr(RTC_SEC, 8'h59); wr(RTC_MIN, 8'h59); wr(RTC_HR, 8'h23);
        wr(RTC_DATE, 8'h28); wr(RTC_MONTH, 8'h02); wr(RTC_YEAR, year);
        wait_tick(3 * TICK_DIV, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL rollover_tick_y%h: no sec_tick within %0d cycles", year, 3 * TICK_DIV);
        end
        for (int i = 0; i < 6; i++) begin
            rd(adr[i], d, v);
            checks++;
            if (d !== exp_d[i] || v !== 1'b1) begin
                errors++;
                $display("FAIL rollover_y%h_addr%h: data=%h valid=%b, want %h 1",
                         year, adr[i], d, v, exp_d[i]);
            end
        end
    endtask

    task automatic test_binary_mode();
        logic [7:0] d;
        logic v;
        int n;
        do_reset();
        wr(RTC_REGB, 8'h06); wr(RTC_SEC, 8'h3B); wr(RTC_MIN, 8'h05);
        wait_tick(3 * TICK_DIV, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL binary_tick: no sec_tick within budget");
        end
        rd(RTC_SEC, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL binary_sec: got %h want 00", d); end
        rd(RTC_MIN, d, v);
        checks++;
        if (d !== 8'h06) begin errors++; $display("FAIL binary_min: got %h want 06", d); end
        rd(RTC_REGC, d, v);
        checks++;
        if (d !== 8'h90) begin errors++; $display("FAIL regc_first: got %h want 90", d); end
        rd(RTC_REGC, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL regc_cleared: got %h want 00", d); end
    endtask

    task automatic test_set_hold();
        logic [7:0] d;
        logic v;
        int ticks;
        int n;
        do_reset();
        wr(RTC_REGB, 8'h82);
        ticks = 0;
        for (int i = 0; i < 3 * TICK_DIV; i++) begin
            step();
            if (sec_tick) ticks++;
        end
        checks++;
        if (ticks != 0) begin errors++; $display("FAIL set_no_tick: got %0d ticks want 0", ticks); end
        rd(RTC_SEC, d, v);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL set_sec_held: got %h want 00", d); end
        wr(RTC_REGB, 8'h02);
        wait_tick(3 * TICK_DIV, n);
        checks++;
        if (n != TICK_DIV) begin
            errors++;
            $display("FAIL set_release_latency: got %0d cycles want %0d", n, TICK_DIV);
        end
        rd(RTC_SEC, d, v);
        checks++;
        if (d !== 8'h01) begin errors++; $display("FAIL set_release_sec: got %h want 01", d); end
    endtask

    task automatic test_alarm_ram();
        logic [7:0] d;
        logic v;
        int n;
        do_reset();
        wr(RTC_SEC_ALM, 8'hC0); wr(RTC_MIN_ALM, 8'h01); wr(RTC_HR_ALM, 8'h00);
        wr(RTC_HR, 8'h00); wr(RTC_MIN, 8'h00); wr(RTC_SEC, 8'h59);
        wr(8'h40, 8'h55); wr(8'hFF, 8'hAA);
        wait_tick(3 * TICK_DIV, n);
        checks++;
        if (n < 0) begin errors++; $display("FAIL alarm_tick: no sec_tick within budget"); end
        rd(RTC_REGC, d, v);
        checks++;
        if (d !== 8'hB0) begin errors++; $display("FAIL alarm_regc: got %h want B0", d); end
        rd(8'h40, d, v);
        checks++;
        if (d !== 8'h55) begin errors++; $display("FAIL ram_40: got %h want 55", d); end
        rd(8'hFF, d, v);
        checks++;
        if (d !== 8'hAA) begin errors++; $display("FAIL ram_ff: got %h want AA", d); end
    endtask

    task automatic test_reset_mid_update();
        logic [7:0] d;
        logic v;
        int edges;
        do_reset();
        // After release the prescaler equals the number of edges seen.
        repeat (TICK_DIV - 3) step();
        rd(RTC_REGA, d, v);
        checks++;
        if (d !== 8'hA0) begin errors++; $display("FAIL uip_window: got %h want A0", d); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_kills_rd_valid: got %b want 0", bus.rd_valid);
        end
        step();
        rst_n = 1'b1;
        edges = 0;
        rd(RTC_REGA, d, v);
        edges++;
        checks++;
        if (d !== 8'h20) begin errors++; $display("FAIL mid_reset_rega: got %h want 20", d); end
        rd(RTC_SEC, d, v);
        edges++;
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL mid_reset_sec: got %h want 00", d); end
        while (edges < 3 * TICK_DIV) begin
            step();
            edges++;
            if (sec_tick) break;
        end
        checks++;
        if (edges != TICK_DIV) begin
            errors++;
            $display("FAIL mid_reset_tick_latency: got %0d cycles want %0d", edges, TICK_DIV);
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.rnw = 1'b1; bus.addr = 8'h00; bus.wrdata = 8'h00;
        test_reset();
        test_rollover(8'h23, 8'h01, 8'h03);
        test_rollover(8'h24, 8'h29, 8'h02);
        test_binary_mode();
        test_set_hold();
        test_alarm_ram();
        test_reset_mid_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gluclock_rtc.md
Name: gluclock_rtc

Overview:
- Synthesizable MC146818-style CMOS/RTC model. It serves the gluclock wait-handshake: a CPU access to the CMOS port raises a request carrying addr, rnw and write data, and this block returns the read data.
- Sits directly downstream of the top-level wait/gluclock logic.
- Replaces the behavioural CMOS emulator in simulation, and is usable on-chip when no AVR RTC is present.
- Holds a BCD/binary calendar clock, status registers A–D, alarm and general-purpose CMOS RAM.

Parameters:
- TICK_DIV, 28000000: fclk cycles per RTC second (the prescaler period).
- UIP_LEAD, 64: fclk cycles before each update during which UIP reads 1.

Ports:
- fclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  one-cycle access strobe (from wait_start_gluclock).
- rnw  in  1  1 = read, 0 = write; sampled with req.
- addr  in  8  CMOS register/RAM address; sampled with req.
- wrdata  in  8  write data; sampled with req.
- rddata  out  8  read data; held until the next read.
- rd_valid  out  1  one-cycle pulse, one cycle after a read req.
- sec_tick  out  1  one-cycle pulse on every completed update (debug/bench).

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: rddata=0x00, rd_valid=0, sec_tick=0, prescaler=0.
  - Time/date: sec=min=hr=0, day-of-week=1, date=1, month=1, year=0.
  - Status: regA=0x20, regB=0x02 (24h, BCD, SET=0), regC=0x00.
  - Alarm registers cleared to 0.
  - RAM 0x0E–0xFF is not cleared: block RAM, contents undefined.
- Address map:
  - 0x00 sec, 0x01 sec-alarm, 0x02 min, 0x03 min-alarm, 0x04 hr, 0x05 hr-alarm, 0x06 dow, 0x07 date, 0x08 month, 0x09 year.
  - 0x0A regA: bit7 UIP is read-only; bits6:0 are stored.
  - 0x0B regB: bit7 SET, bit5 AIE (stored only), bit4 UIE (stored only), bit2 DM (1 = binary), bit1 24/12 (reads back as written; the clock is always 24h).
  - 0x0C regC: read-only; bit7 IRQF = AF|UF, bit5 AF, bit4 UF. Writes are ignored.
  - 0x0D regD: always reads 0x80 (VRT); writes are ignored.
  - 0x0E–0xFF: RAM.
- Access latency:
  - Read: req at cycle N → rddata valid and rd_valid=1 at N+1.
  - Write: takes effect at N+1.
  - req is a pulse; back-to-back reqs on consecutive cycles are legal and each is served.
- Prescaler:
  - Counts 0..TICK_DIV-1 while SET=0, then wraps to 0.
  - While SET=1, the prescaler is held at 0 and no update occurs.
  - UIP=1 while prescaler ≥ TICK_DIV-UIP_LEAD.
- Update (single cycle, at prescaler wrap):
  - Seconds increment with cascade sec→min→hr→date/dow→month→year.
  - Each field wraps to its minimum when value ≥ max, so out-of-range written values recover on the next carry.
  - Max values: sec 59, min 59, hr 23, dow 7→1, month 12→1, year 99→0.
  - Date max: 31/30 by month; February is 29 if year%4==0, else 28.
  - All arithmetic is BCD when DM=0 and binary when DM=1. DM changes do not convert stored values.
- On each update:
  - UF←1 and sec_tick pulses.
  - AF←1 if (sec,min,hr) equals the alarm registers. An alarm register value with bits7:6=11 matches any value.
- Simultaneous events:
  - Write to a time field in the update cycle: the written value wins for that field; other fields update normally; no carry comes out of the written field.
  - Read in the update cycle returns the pre-update value.
  - Reading regC returns the current flags, then clears AF/UF. If an update sets a flag in that same cycle, the flag stays set.
- Reset mid-update or mid-access: all state returns to the reset values immediately; no pending rd_valid is emitted.

Decomposition:
- Package gluclock_rtc_pkg:
  - Register address constants: RTC_SEC … RTC_REGD, RTC_RAM_BASE.
  - Bit positions: SET, DM, H24, UIP, AF, UF, IRQF.
  - Month-length function, including the leap-year rule.
- Sub-module rtc_field_cnt, instanced once per time field:
  - Inputs: inc, dm, min, max, wr_en, wr_val.
  - Outputs: value, carry.
  - Performs the BCD/binary increment and wrap.

Test Plan:
1. Reset, then read 0x0D, 0x0B, 0x0A, 0x07 → rddata 0x80, 0x02, 0x20, 0x01, each with rd_valid exactly one cycle after req.
2. Set TICK_DIV=100. Write sec=0x59, min=0x59, hr=0x23, date=0x28, month=0x02, year=0x23. After one tick read back → 0x00, 0x00, 0x00, 0x01, 0x03, 0x23. Repeat with year=0x24 → date 0x29, month 0x02.
3. Write regB=0x06 (DM=1), sec=0x3B, min=0x05. After one tick → sec=0x00, min=0x06; regC reads 0x90 and then 0x00 on a second read.
4. Write regB=0x82 (SET=1) and wait 3 tick periods → sec unchanged and sec_tick never pulses. Write regB=0x02 → sec increments exactly TICK_DIV cycles later.
5. Alarm: write sec-alarm=0xC0, min-alarm=0x01, hr-alarm=0x00, then time 00:00:59 → after the tick, regC=0xB0. Also write 0x55 to 0x40 and 0xAA to 0xFF → readback 0x55, 0xAA.
6. Assert rst_n=0 for 1 cycle while prescaler=TICK_DIV-2 and UIP=1 → regA reads 0x20 (UIP=0), sec=0x00, and no sec_tick until TICK_DIV cycles after release.
